// File: rtl/fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_hazard_ctrl
//   Hazard and fetch sequencer for the IF/ID pipeline register and the PC
//   stage. It combines load-use hazards, E-stage redirects and a blocking,
//   ack-based instruction memory into StallF/StallD/FlushD/FlushE. When a
//   redirect arrives while a fetch is still outstanding, the target is held
//   and replayed once that stale fetch completes.
//
//   Optional feature macro: HZ_PERF_CNT_EN
//     defined     : o_cnt_stall / o_cnt_flush are saturating cycle counters
//     not defined : both ports are tied to 0 and no counter flops exist
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-low reset
//   i_rs1_D, i_rs2_D      source registers of the instruction in D
//   i_rd_E, i_memread_E   destination / load flag of the instruction in E
//   i_pcsrc_E             E-stage branch/jump taken
//   i_pc_target_E         redirect target from E
//   i_imem_ack            current fetch returns a valid instruction
//   o_imem_req            fetch request (high whenever out of reset)
//   o_StallF, o_StallD    hold PC / hold IF/ID
//   o_FlushD, o_FlushE    bubble into IF/ID / ID/EX
//   o_redir_vld, o_redir_pc  PC mux select and redirect PC
//   o_state               RUN=0, MISS=1, DRAIN=2
//   o_err                 sticky fetch timeout
//   o_cnt_stall           cycles with o_StallF=1
//   o_cnt_flush           cycles with o_FlushD=1
// ---------------------------------------------------------------------------
module fetch_hazard_ctrl #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_rs1_D,
  input  logic [REG_W-1:0] i_rs2_D,
  input  logic [REG_W-1:0] i_rd_E,
  input  logic             i_memread_E,
  input  logic             i_pcsrc_E,
  input  logic [31:0]      i_pc_target_E,
  input  logic             i_imem_ack,
  output logic             o_imem_req,
  output logic             o_StallF,
  output logic             o_StallD,
  output logic             o_FlushD,
  output logic             o_FlushE,
  output logic             o_redir_vld,
  output logic [31:0]      o_redir_pc,
  output logic [1:0]       o_state,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt_stall,
  output logic [CNT_W-1:0] o_cnt_flush
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned TMR_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MISS_TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_tgt;
  logic               w_tgt_load;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_inc;
  logic               w_tick;
  logic               r_err;
  logic               w_lduse;

  assign w_lduse = i_memread_E & (i_rd_E != '0) &
                   ((i_rd_E == i_rs1_D) | (i_rd_E == i_rs2_D));

  // Timer advances only while waiting on an outstanding fetch.
  assign w_tick      = (r_state != RUN) & ~i_imem_ack;
  assign w_timer_inc = r_timer + TMR_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    o_StallF    = 1'b0;
    o_StallD    = 1'b0;
    o_FlushD    = 1'b0;
    o_FlushE    = 1'b0;
    o_redir_vld = 1'b0;
    o_redir_pc  = i_pc_target_E;
    w_state_nxt = r_state;
    w_tgt_load  = 1'b0;

    if (!i_rst) begin
      o_FlushD    = 1'b1;
      o_FlushE    = 1'b1;
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        DRAIN: begin
          // Stale fetch outstanding: redirect and load-use are ignored;
          // the stale instruction is discarded when it finally returns.
          o_FlushD = 1'b1;
          if (i_imem_ack) begin
            o_redir_vld = 1'b1;
            o_redir_pc  = r_tgt;
            w_state_nxt = RUN;
          end else begin
            o_StallF = 1'b1;
          end
        end
        default: begin
          if (i_pcsrc_E && i_imem_ack) begin
            o_redir_vld = 1'b1;
            o_FlushD    = 1'b1;
            o_FlushE    = 1'b1;
            w_state_nxt = RUN;
          end else if (i_pcsrc_E) begin
            o_StallF    = 1'b1;
            o_FlushD    = 1'b1;
            o_FlushE    = 1'b1;
            w_tgt_load  = 1'b1;
            w_state_nxt = DRAIN;
          end else if (w_lduse) begin
            o_StallF    = 1'b1;
            o_StallD    = 1'b1;
            o_FlushE    = 1'b1;
            w_state_nxt = i_imem_ack ? RUN : MISS;
          end else if (!i_imem_ack) begin
            o_StallF    = 1'b1;
            o_FlushD    = 1'b1;
            w_state_nxt = MISS;
          end else begin
            w_state_nxt = RUN;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State, held target, timeout timer and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= RUN;
      r_tgt   <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tgt_load) begin
        r_tgt <= i_pc_target_E;
      end
      if (!w_tick) begin
        r_timer <= '0;
      end else if (r_timer != TMR_MAX) begin
        // Saturates at the threshold so a long stall never wraps.
        r_timer <= w_timer_inc;
        if (w_timer_inc == TMR_MAX) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_imem_req = i_rst;
  assign o_state    = r_state;
  assign o_err      = r_err;

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if (o_StallF && (r_cnt_stall != '1)) begin
        r_cnt_stall <= r_cnt_stall + CNT_W'(1);
      end
      if (o_FlushD && (r_cnt_flush != '1)) begin
        r_cnt_flush <= r_cnt_flush + CNT_W'(1);
      end
    end
  end

  assign o_cnt_stall = r_cnt_stall;
  assign o_cnt_flush = r_cnt_flush;
`else
  assign o_cnt_stall = '0;
  assign o_cnt_flush = '0;
`endif

endmodule
